vcnpu_dram_resp: RTL

VCNPU_DRAM_RESP -- requirements
Module: vcnpu_dram_resp

---
 rtl/vcnpu_pkg.sv | 17 +
 rtl/vcnpu_req_fifo.sv | 42 ++++
 rtl/vcnpu_dram_resp.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/vcnpu_pkg.sv
// Shared types for the DRAM responder model: FSM states, queued request entry, error fill word.
// Request fields are sized for ADDR_W <= 32 and LEN_W <= 16; wider instances truncate on enqueue.
package vcnpu_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    localparam int REQ_ADDR_W = 32;
    localparam int REQ_LEN_W  = 16;

    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_LEN_W-1:0]  len;
    } req_t;

    localparam logic [31:0] ERR_FILL = 32'hDEAD_BEEF;

endpackage

// File: rtl/vcnpu_req_fifo.sv
// Request queue: DEPTH-entry FIFO (DEPTH a power of two >= 2), head visible combinationally.
// Push is ignored when full and pop is ignored when empty; push and pop may share an edge.
module vcnpu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_din,
    input  logic                     i_pop,
    output logic [W-1:0]             o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_cnt
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [PW:0]  r_wp;
    logic [PW:0]  r_rp;

    assign o_cnt   = r_wp - r_rp;
    assign o_full  = (o_cnt == (PW+1)'(DEPTH));
    assign o_empty = (r_wp == r_rp);
    assign o_dout  = r_mem[r_rp[PW-1:0]];

    always_ff @(posedge clk) begin
        if (i_push && !o_full) r_mem[r_wp[PW-1:0]] <= i_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (i_push && !o_full) r_wp <= r_wp + 1'b1;
            if (i_pop && !o_empty) r_rp <= r_rp + 1'b1;
        end
    end

endmodule

// File: rtl/vcnpu_dram_resp.sv
// DRAM read responder: queued bursts from a preloadable store, first beat LAT cycles after ack, beats held under dram_ready=0.
// Optional range checking (VCNPU_DRAM_ADDR_CHECK_EN) replaces out-of-window beats with the error fill and sets sticky err.
module vcnpu_dram_resp
    import vcnpu_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 32,
    parameter int                LEN_W     = 16,
    parameter int                MEM_DEPTH = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1000_0000,
    parameter int                LAT       = 2,
    parameter int                QDEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         dram_req,
    input  logic [ADDR_W-1:0]            dram_addr,
    input  logic [LEN_W-1:0]             dram_len,
    output logic                         dram_ack,
    output logic                         dram_data_valid,
    output logic [DATA_W-1:0]            dram_data_in,
    input  logic                         dram_ready,
    input  logic                         load_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] load_addr,
    input  logic [DATA_W-1:0]            load_data,
    output logic                         busy,
    output logic                         err
);
    localparam int             IDX_W   = $clog2(MEM_DEPTH);
    localparam int             QC_W    = $clog2(QDEPTH) + 1;
    localparam logic [3:0]     WAIT_LD = (LAT >= 2) ? 4'(LAT - 2) : 4'd0;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_beat;
    logic [3:0]          r_cnt;
    logic                r_ack;
    logic                r_valid;
    logic                r_err;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   r_mem [MEM_DEPTH];

    req_t                w_push_ent;
    req_t                w_head;
    logic                w_fifo_full;
    logic                w_q_empty;
    logic [QC_W-1:0]     w_q_cnt;
    logic                w_q_full;
    logic                w_accept;
    logic                w_pop;
    logic                w_hs;
    logic                w_last;
    logic                w_wait_done;
    logic                w_start;
    logic                w_load;
    logic [ADDR_W-1:0]   w_head_addr;
    logic [LEN_W-1:0]    w_head_len;
    logic [ADDR_W-1:0]   w_base;
    logic [LEN_W-1:0]    w_ld_beat;
    logic [ADDR_W-1:0]   w_beat_addr;
    logic                w_oor;
    logic [DATA_W-1:0]   w_rd;

    assign w_push_ent  = '{addr: REQ_ADDR_W'(dram_addr), len: REQ_LEN_W'(dram_len)};
    assign w_head_addr = ADDR_W'(w_head.addr);
    assign w_head_len  = LEN_W'(w_head.len);

    // The request in service still counts as outstanding, so QDEPTH bounds queue plus active burst.
    assign w_q_full    = w_fifo_full || ((r_state != IDLE) && (w_q_cnt == QC_W'(QDEPTH - 1)));
    assign w_accept    = dram_req && !r_ack && !w_q_full;
    assign w_hs        = r_valid && dram_ready;
    assign w_last      = (r_beat == r_len - LEN_W'(1));
    assign w_wait_done = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_start     = (w_wait_done && (r_len != '0)) ||
                         ((LAT == 1) && (r_state == IDLE) && !w_q_empty && (w_head_len != '0));
    assign w_load      = w_start || (w_hs && !w_last);
    assign w_pop       = !w_q_empty && ((r_state == IDLE) || ((r_state == BURST) && w_hs && w_last));

    assign w_base      = (r_state == IDLE) ? w_head_addr : r_addr;
    assign w_ld_beat   = (r_state == BURST) ? r_beat + LEN_W'(1) : '0;
    assign w_beat_addr = w_base + ADDR_W'(w_ld_beat);

`ifdef VCNPU_DRAM_ADDR_CHECK_EN
    logic [ADDR_W-1:0] w_off;
    assign w_off = w_beat_addr - BASE_ADDR;
    assign w_oor = (w_off >= ADDR_W'(MEM_DEPTH));
    assign w_rd  = w_oor ? DATA_W'(ERR_FILL) : r_mem[w_off[IDX_W-1:0]];
`else
    assign w_oor = 1'b0;
    assign w_rd  = r_mem[IDX_W'(w_beat_addr - BASE_ADDR)];
`endif

    vcnpu_req_fifo #(.DEPTH(QDEPTH), .W($bits(req_t))) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_din   (w_push_ent),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_q_empty),
        .o_cnt   (w_q_cnt)
    );

    always_ff @(posedge clk) begin
        if (load_en) r_mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_ack <= w_accept;
            if (w_load) begin
                r_data <= w_rd;
                r_err  <= r_err | w_oor;
            end
            case (r_state)
                IDLE: if (!w_q_empty) begin
                    r_addr <= w_head_addr;
                    r_len  <= w_head_len;
                    r_cnt  <= WAIT_LD;
                    r_beat <= '0;
                    if (w_start) begin
                        r_state <= BURST;
                        r_valid <= 1'b1;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end else if (r_len != '0) begin
                    r_state <= BURST;
                    r_beat  <= '0;
                    r_valid <= 1'b1;
                end else begin
                    r_state <= IDLE;
                end
                BURST: if (w_hs) begin
                    if (!w_last) begin
                        r_beat <= r_beat + LEN_W'(1);
                    end else begin
                        r_valid <= 1'b0;
                        if (!w_q_empty) begin
                            r_addr  <= w_head_addr;
                            r_len   <= w_head_len;
                            r_cnt   <= WAIT_LD;
                            r_state <= WAIT;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dram_ack        = r_ack;
    assign dram_data_valid = r_valid;
    assign dram_data_in    = r_data;
    assign busy            = !w_q_empty || (r_state != IDLE);
    assign err             = r_err;

endmodule
